// File: rtl/i2s_transmitter_if.sv
// Bundle of the upstream sample handshake and the I2S bus pins of i2s_transmitter.
// The master modport is the transmitter's view; slave is the upstream source / DAC side.
interface i2s_transmitter_if #(
    parameter int bits_per_word = 16
);
    logic                     data_valid;
    logic                     data_ready;
    logic [bits_per_word-1:0] data_in_0;
    logic [bits_per_word-1:0] data_in_1;
    logic                     i2s_data;
    logic                     bck;
    logic                     lrck;

    modport master (
        input  data_valid,
        input  data_in_0,
        input  data_in_1,
        output data_ready,
        output i2s_data,
        output bck,
        output lrck
    );

    modport slave (
        output data_valid,
        output data_in_0,
        output data_in_1,
        input  data_ready,
        input  i2s_data,
        input  bck,
        input  lrck
    );
endinterface

// File: rtl/i2s_transmitter.sv
// Philips I2S master transmitter: derives bck/lrck from the system clock and shifts stereo samples MSB first.
// Optional saturating underrun counter on o_underrun_count when I2S_TX_UNDERRUN_COUNT_EN is defined.
module i2s_transmitter #(
    parameter int bits_per_word = 16,
    parameter int bck_divisor   = 4
) (
    input  logic                 i_clock,
    input  logic                 i_reset,
    i2s_transmitter_if.master    i2s_bus,
    output logic                 o_underrun
`ifdef I2S_TX_UNDERRUN_COUNT_EN
    ,
    output logic [15:0]          o_underrun_count
`endif
);
    localparam int FRAME_BITS = 2 * bits_per_word;
    localparam int DIV_W      = $clog2(bck_divisor);
    localparam int BIT_W      = $clog2(FRAME_BITS);

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(bck_divisor - 1);
    localparam logic [DIV_W-1:0] DIV_HALF = DIV_W'(bck_divisor / 2);
    localparam logic [DIV_W-1:0] DIV_ONE  = DIV_W'(1);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(FRAME_BITS - 1);
    localparam logic [BIT_W-1:0] BIT_WORD = BIT_W'(bits_per_word);
    localparam logic [BIT_W-1:0] BIT_ONE  = BIT_W'(1);

    logic [DIV_W-1:0]      r_div_cnt;
    logic [BIT_W-1:0]      r_bit_cnt;
    logic                  r_bck;
    logic                  r_lrck;
    logic                  r_i2s_data;
    logic                  r_data_ready;
    logic                  r_underrun;
    logic [FRAME_BITS-1:0] r_shift;
    logic [FRAME_BITS-1:0] r_hold;

    logic                  w_fe;
    logic                  w_wrap;
    logic                  w_accept;
    logic                  w_underrun_event;
    logic [DIV_W-1:0]      w_div_next;
    logic [BIT_W-1:0]      w_bit_next;

    // fe is the last system clock of a bck period; bck, lrck and data all move on that edge.
    assign w_fe             = (r_div_cnt == DIV_LAST);
    assign w_wrap           = w_fe && (r_bit_cnt == BIT_LAST);
    assign w_div_next       = w_fe ? '0 : r_div_cnt + DIV_ONE;
    assign w_bit_next       = w_wrap ? '0 : (w_fe ? r_bit_cnt + BIT_ONE : r_bit_cnt);
    assign w_accept         = i2s_bus.data_valid && r_data_ready;
    assign w_underrun_event = w_wrap && r_data_ready;

    // NOTE: every state register below uses <= so all of them see the pre-edge values of each other.
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_div_cnt    <= '0;
            r_bit_cnt    <= '0;
            r_bck        <= 1'b0;
            r_lrck       <= 1'b0;
            r_i2s_data   <= 1'b0;
            r_data_ready <= 1'b1;
            r_underrun   <= 1'b0;
            r_shift      <= '0;
        end else begin
            r_div_cnt  <= w_div_next;
            r_bck      <= (w_div_next >= DIV_HALF);
            r_bit_cnt  <= w_bit_next;
            r_lrck     <= (w_bit_next >= BIT_WORD);
            r_underrun <= w_underrun_event;

            // The output flop lags the shifter by one slot, giving the I2S one-bck data delay.
            if (w_fe) begin
                r_i2s_data <= r_shift[FRAME_BITS-1];
                if (w_wrap) begin
                    r_shift <= r_data_ready ? '0 : r_hold;
                end else begin
                    r_shift <= {r_shift[FRAME_BITS-2:0], 1'b0};
                end
            end

            // A sample accepted on the load edge itself is kept for the following frame.
            if (w_wrap && !r_data_ready) begin
                r_data_ready <= 1'b1;
            end else if (w_accept) begin
                r_data_ready <= 1'b0;
            end
        end
    end

    // NOTE: the holding payload needs no reset; r_data_ready alone says whether it is valid.
    always_ff @(posedge i_clock) begin
        if (w_accept) begin
            r_hold <= {i2s_bus.data_in_0, i2s_bus.data_in_1};
        end
    end

`ifdef I2S_TX_UNDERRUN_COUNT_EN
    logic [15:0] r_underrun_count;

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_underrun_count <= '0;
        end else if (w_underrun_event && (r_underrun_count != 16'hFFFF)) begin
            r_underrun_count <= r_underrun_count + 16'd1;
        end
    end

    assign o_underrun_count = r_underrun_count;
`endif

    assign i2s_bus.bck        = r_bck;
    assign i2s_bus.lrck       = r_lrck;
    assign i2s_bus.i2s_data   = r_i2s_data;
    assign i2s_bus.data_ready = r_data_ready;
    assign o_underrun         = r_underrun;
endmodule
